// File: rtl/vga_timing_ctrl_if.sv
// Configuration channel of the VGA timing controller: a valid/ready offer of a
// packed 8-field timing word plus a one-cycle reject pulse back to the sender.
interface vga_timing_ctrl_if #(
  parameter int W = 12
);
  logic           i_cfg_valid;
  logic           o_cfg_ready;
  logic [8*W-1:0] i_cfg_data;
  logic           o_cfg_err;

  // System control side: offers configurations
  modport master (
    output i_cfg_valid,
    output i_cfg_data,
    input  o_cfg_ready,
    input  o_cfg_err
  );

  // Timing controller side: accepts and validates configurations
  modport slave (
    input  i_cfg_valid,
    input  i_cfg_data,
    output o_cfg_ready,
    output o_cfg_err
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing controller. Runs the h/v counters under a run/drain/idle
// FSM, registers position/sync/de/sof one cycle behind the counter state,
// and shadows new timing configurations so they only take effect on a frame
// boundary (or immediately while idle).
module vga_timing_ctrl #(
  parameter int   W        = 12,
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 348,
  parameter int   V_ACTIVE = 1200,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 291,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  vga_timing_ctrl_if.slave cfg,
  output logic             o_busy,
  output logic [W-1:0]     o_x,
  output logic [W-1:0]     o_y,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de,
  output logic             o_sof
);

  // Field order matches the wire format: h_active is the most significant field.
  typedef struct packed {
    logic [W-1:0] h_active;
    logic [W-1:0] h_fp;
    logic [W-1:0] h_sync;
    logic [W-1:0] h_bp;
    logic [W-1:0] v_active;
    logic [W-1:0] v_fp;
    logic [W-1:0] v_sync;
    logic [W-1:0] v_bp;
  } timing_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam timing_t CFG_DEF = timing_t'({W'(H_ACTIVE), W'(H_FP), W'(H_SYNC), W'(H_BP),
                                           W'(V_ACTIVE), W'(V_FP), W'(V_SYNC), W'(V_BP)});

  // A config is usable only if every field is non-zero and both totals fit in
  // W bits. Sums are taken two bits wider so four W-bit fields cannot wrap.
  function automatic logic cfg_ok(input timing_t c);
    logic [W+1:0] hsum;
    logic [W+1:0] vsum;
    logic         nz;
    hsum = {2'b00, c.h_active} + {2'b00, c.h_fp} + {2'b00, c.h_sync} + {2'b00, c.h_bp};
    vsum = {2'b00, c.v_active} + {2'b00, c.v_fp} + {2'b00, c.v_sync} + {2'b00, c.v_bp};
    nz   = (c.h_active != '0) && (c.h_fp != '0) && (c.h_sync != '0) && (c.h_bp != '0) &&
           (c.v_active != '0) && (c.v_fp != '0) && (c.v_sync != '0) && (c.v_bp != '0);
    return nz && (hsum[W+1:W] == 2'b00) && (vsum[W+1:W] == 2'b00);
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] h_q, v_q;
  timing_t      act_q, shd_q;
  logic         shd_full_q;
  logic         err_q;

  // Derived boundaries of the active timing; all fit in W bits because only
  // validated configs ever become active.
  logic [W-1:0] hs_beg, hs_end, h_tot;
  logic [W-1:0] vs_beg, vs_end, v_tot;
  logic         h_last, v_last, frame_end, counting;
  logic         xfer, commit;

  assign hs_beg    = act_q.h_active + act_q.h_fp;
  assign hs_end    = hs_beg + act_q.h_sync;
  assign h_tot     = hs_end + act_q.h_bp;
  assign vs_beg    = act_q.v_active + act_q.v_fp;
  assign vs_end    = vs_beg + act_q.v_sync;
  assign v_tot     = vs_end + act_q.v_bp;

  assign h_last    = (h_q == h_tot - W'(1));
  assign v_last    = (v_q == v_tot - W'(1));
  assign frame_end = h_last && v_last;
  assign counting  = (state_q != ST_IDLE);

  // Shadow is single-entry: ready means empty, so a transfer and a commit can
  // never coincide. While scanning, commit waits for the frame wrap.
  assign xfer      = cfg.i_cfg_valid && !shd_full_q;
  assign commit    = shd_full_q && (!counting || frame_end);

  assign cfg.o_cfg_ready = !shd_full_q;
  assign cfg.o_cfg_err   = err_q;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: drain finishes the frame unless run is re-requested
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_en) state_d = ST_RUN;
      ST_RUN:   if (!i_en) state_d = frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (i_en)           state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Scan counters: held at origin while idle, wrap at the active totals
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (!counting) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_last) begin
      h_q <= '0;
      v_q <= v_last ? '0 : v_q + W'(1);
    end else begin
      h_q <= h_q + W'(1);
    end
  end

  // Shadow load on handshake, validate-and-commit at the boundary
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      act_q      <= CFG_DEF;
      shd_q      <= CFG_DEF;
      shd_full_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (xfer) begin
        shd_q      <= timing_t'(cfg.i_cfg_data);
        shd_full_q <= 1'b1;
      end else if (commit) begin
        shd_full_q <= 1'b0;
        if (cfg_ok(shd_q)) act_q <= shd_q;
        else               err_q <= 1'b1;
      end
    end
  end

  // Registered video outputs, one cycle behind the counter state
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_x     <= '0;
      o_y     <= '0;
      o_de    <= 1'b0;
      o_hsync <= ~SYNC_POL;
      o_vsync <= ~SYNC_POL;
      o_sof   <= 1'b0;
      o_busy  <= 1'b0;
    end else if (counting) begin
      o_x     <= h_q;
      o_y     <= v_q;
      o_de    <= (h_q < act_q.h_active) && (v_q < act_q.v_active);
      o_hsync <= ((h_q >= hs_beg) && (h_q < hs_end)) ? SYNC_POL : ~SYNC_POL;
      o_vsync <= ((v_q >= vs_beg) && (v_q < vs_end)) ? SYNC_POL : ~SYNC_POL;
      o_sof   <= (h_q == '0) && (v_q == '0);
      o_busy  <= 1'b1;
    end else begin
      o_x     <= '0;
      o_y     <= '0;
      o_de    <= 1'b0;
      o_hsync <= ~SYNC_POL;
      o_vsync <= ~SYNC_POL;
      o_sof   <= 1'b0;
      o_busy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: directed phases plus a randomized run, all
// compared cycle by cycle against a linear-pixel-index reference model.
module tb_vga_timing_ctrl;
  localparam int   W   = 12;
  localparam logic POL = 1'b0;
  localparam int   LIM = 5000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         busy, hs, vs, de, sof;
  logic [W-1:0] x, y;

  vga_timing_ctrl_if #(.W(W)) cfg_if ();

  vga_timing_ctrl #(.W(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .cfg     (cfg_if),
    .o_busy  (busy),
    .o_x     (x),
    .o_y     (y),
    .o_hsync (hs),
    .o_vsync (vs),
    .o_de    (de),
    .o_sof   (sof)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_cfgerr = 0;

  // Reference model: scan position is one linear pixel index within the frame
  int           m_cfg[8];
  int           m_shd[8];
  bit           m_full, m_cnt, m_xfer;
  int           m_pos;
  logic [W-1:0] e_x, e_y;
  logic         e_de, e_hs, e_vs, e_sof, e_busy, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8*W-1:0] mk(input int a, b, c, d, e, f, g, h);
    return {W'(a), W'(b), W'(c), W'(d), W'(e), W'(f), W'(g), W'(h)};
  endfunction

  function automatic logic [8*W-1:0] rnd_cfg();
    int f[8];
    for (int i = 0; i < 8; i++) f[i] = $urandom_range(1, 3);
    if ($urandom_range(0, 7) == 0) f[$urandom_range(0, 7)] = 0;
    if ($urandom_range(0, 15) == 0) begin f[0] = 4000; f[3] = 200; end
    return mk(f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7]);
  endfunction

  task automatic idle_outs();
    e_x = '0; e_y = '0; e_de = 0; e_hs = ~POL; e_vs = ~POL; e_sof = 0; e_busy = 0;
  endtask

  task automatic model_reset();
    m_cfg = '{1920, 88, 44, 348, 1200, 3, 6, 291};
    m_full = 0; m_cnt = 0; m_pos = 0; m_xfer = 0; e_err = 0;
    idle_outs();
  endtask

  task automatic model_edge();
    int ht, vt, hx, vy, hsum, vsum;
    bit wrap, ok;
    ht = m_cfg[0] + m_cfg[1] + m_cfg[2] + m_cfg[3];
    vt = m_cfg[4] + m_cfg[5] + m_cfg[6] + m_cfg[7];
    e_err = 0;
    if (m_cnt) begin
      hx = m_pos % ht;
      vy = m_pos / ht;
      e_x = W'(hx); e_y = W'(vy);
      e_de = (hx < m_cfg[0]) && (vy < m_cfg[4]);
      e_hs = (hx >= m_cfg[0] + m_cfg[1] && hx < m_cfg[0] + m_cfg[1] + m_cfg[2]) ? POL : ~POL;
      e_vs = (vy >= m_cfg[4] + m_cfg[5] && vy < m_cfg[4] + m_cfg[5] + m_cfg[6]) ? POL : ~POL;
      e_sof = (m_pos == 0);
      e_busy = 1;
    end else begin
      idle_outs();
    end
    wrap = m_cnt && (m_pos == ht * vt - 1);
    m_xfer = cfg_if.i_cfg_valid && !m_full;
    if (m_full && (!m_cnt || wrap)) begin
      hsum = m_shd[0] + m_shd[1] + m_shd[2] + m_shd[3];
      vsum = m_shd[4] + m_shd[5] + m_shd[6] + m_shd[7];
      ok = (hsum < (1 << W)) && (vsum < (1 << W));
      for (int i = 0; i < 8; i++) if (m_shd[i] == 0) ok = 0;
      if (ok) m_cfg = m_shd;
      else    e_err = 1;
      m_full = 0;
    end else if (m_xfer) begin
      for (int i = 0; i < 8; i++) m_shd[i] = int'(cfg_if.i_cfg_data[(7-i)*W +: W]);
      m_full = 1;
    end
    m_pos = (m_cnt && !wrap) ? m_pos + 1 : 0;
    m_cnt = en || (m_cnt && !wrap);
  endtask

  task automatic check_all();
    chk("x",    32'(x),   32'(e_x));
    chk("y",    32'(y),   32'(e_y));
    chk("de",   32'(de),  32'(e_de));
    chk("hs",   32'(hs),  32'(e_hs));
    chk("vs",   32'(vs),  32'(e_vs));
    chk("sof",  32'(sof), 32'(e_sof));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("err",  32'(cfg_if.o_cfg_err), 32'(e_err));
    chk("rdy",  32'(cfg_if.o_cfg_ready), 32'(!m_full));
  endtask

  // One clock: model follows the edge, DUT sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    check_all();
    if (cfg_if.o_cfg_err) n_cfgerr++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset between clock edges, checked before the next edge
  task automatic do_reset();
    #2;
    rst = 0; en = 0; cfg_if.i_cfg_valid = 0;
    #1;
    model_reset();
    check_all();
    ticks(2);
    rst = 1;
  endtask

  task automatic offer(input logic [8*W-1:0] d);
    int n = 0;
    cfg_if.i_cfg_valid = 1;
    cfg_if.i_cfg_data  = d;
    do begin tick(); n++; end while (!m_xfer && n < LIM);
    chk("offer_to", 32'(n < LIM), 32'd1);
    cfg_if.i_cfg_valid = 0;
    cfg_if.i_cfg_data  = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(m_cnt && m_pos == p) && n < LIM) begin tick(); n++; end
    chk("wait_to", 32'(n < LIM), 32'd1);
  endtask

  initial begin
    int de0, hs0, hs_x, sof_i, last_sof, nb;
    cfg_if.i_cfg_valid = 0;
    cfg_if.i_cfg_data  = '0;
    model_reset();
    ticks(2);
    rst = 1;
    ticks(2);

    // Default timing: first line geometry and sof latency
    en = 1;
    de0 = 0; hs0 = 0; hs_x = -1; sof_i = -1;
    for (int i = 0; i < 2600; i++) begin
      tick();
      if (busy && y == 0 && de) de0++;
      if (busy && y == 0 && hs == POL) begin hs0++; if (hs_x < 0) hs_x = int'(x); end
      if (sof && sof_i < 0) sof_i = i;
    end
    chk("sof_lat", 32'(sof_i), 32'd1);
    chk("de_line0", 32'(de0), 32'd1920);
    chk("hs_width", 32'(hs0), 32'd44);
    chk("hs_start", 32'(hs_x), 32'd2008);

    // Shadow a config mid-frame, then reset: default timing must come back
    offer(mk(4, 1, 2, 1, 3, 1, 1, 1));
    ticks(10);
    do_reset();
    en = 1;
    ticks(300);
    do_reset();

    // Small config committed in idle; sof period is htot*vtot = 48
    offer(mk(4, 1, 2, 1, 3, 1, 1, 1));
    ticks(2);
    en = 1;
    last_sof = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (sof) begin
        if (last_sof >= 0) chk("sof_per", 32'(i - last_sof), 32'd48);
        last_sof = i;
      end
    end

    // Mid-frame change, then a second offer that must stall for the shadow
    ticks(13);
    offer(mk(3, 1, 1, 1, 2, 1, 1, 1));
    offer(mk(2, 1, 1, 1, 2, 1, 1, 1));
    ticks(120);

    // Rejected configs: zero field, then line total overflow
    n_cfgerr = 0;
    offer(mk(4, 1, 0, 1, 3, 1, 1, 1));
    offer(mk(4000, 88, 44, 348, 3, 1, 1, 1));
    ticks(60);
    chk("err_cnt", 32'(n_cfgerr), 32'd2);

    // Drop run at (3,2) of the small config: busy through (7,5)
    offer(mk(4, 1, 2, 1, 3, 1, 1, 1));
    ticks(60);
    wait_pos(19);
    en = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (busy) nb++; end
    chk("drain_busy", 32'(nb), 32'd29);

    // Re-request run during drain: counting continues without a gap
    en = 1;
    wait_pos(10);
    en = 0;
    ticks(5);
    en = 1;
    ticks(100);

    // Randomized run requests and config offers
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (cfg_if.i_cfg_valid && m_xfer) cfg_if.i_cfg_valid = 0;
      if (!cfg_if.i_cfg_valid) begin
        cfg_if.i_cfg_data = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 19) == 0) begin
          cfg_if.i_cfg_valid = 1;
          cfg_if.i_cfg_data  = rnd_cfg();
        end
      end
      if (en && $urandom_range(0, 49) == 0) en = 0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1;
    end
    cfg_if.i_cfg_valid = 0;

    // Reset while running with a full shadow
    en = 1;
    ticks(3);
    offer(mk(3, 2, 2, 2, 3, 2, 2, 2));
    do_reset();
    en = 1;
    ticks(300);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
